// File: rtl/pwm_pkg.sv
// Purpose : shared types and constants for the PWM generator / duty-meter pair.
// Latency : n/a (package only).
// Backpressure : n/a (package only).
package pwm_pkg;

    // Period of the companion PWM generator, in clock cycles.
    localparam int PWM_PERIOD = 50;

    // Default width of the duty-meter high-time and period counters.
    localparam int CNT_W_DEF = 8;

    // Duty-meter measurement FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_sync_edge.sv
// Purpose : synchronise an asynchronous 1-bit input and flag its rising/falling edges.
// Latency : SYNC_STAGES clocks from pin to o_lvl; edge flags are combinational on o_lvl.
// Backpressure : none; free-running every clock.
//
// Ports:
//   clock   - sole clock, rising edge
//   reset_n - asynchronous active-low reset, clears all flops to 0
//   i_async - asynchronous input
//   o_lvl   - synchronised level
//   o_rise  - o_lvl is 1 this cycle and was 0 last cycle
//   o_fall  - o_lvl is 0 this cycle and was 1 last cycle
module pwm_sync_edge #(
    parameter int SYNC_STAGES = 2   // must be at least 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_async,
    output logic o_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_lvl_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_lvl_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_lvl_d <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_lvl  = r_sync[SYNC_STAGES-1];
    assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_lvl_d;
    assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_lvl_d;

endmodule

// File: rtl/pwm_duty_meter.sv
// Purpose : measure PWM high time and period (rising edge to rising edge) and flag stuck inputs.
// Latency : SYNC_STAGES+2 clocks from pin rising edge to meas_valid.
// Backpressure : valid held until accepted; a new measurement overwrites a pending one and sets meas_overrun.
//
// Ports:
//   clock, reset_n - rising-edge clock, asynchronous active-low reset
//   pwm_in         - PWM waveform, asynchronous to clock
//   meas_high      - high time of the last published measurement (cycles)
//   meas_period    - period of the last published measurement (cycles)
//   meas_timeout   - published measurement came from a stuck-input timeout
//   meas_overrun   - an unconsumed measurement was overwritten
//   meas_valid     - measurement available
//   meas_ready     - consumer accepts on meas_valid && meas_ready
module pwm_duty_meter
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] meas_high,
    output logic [CNT_W-1:0] meas_period,
    output logic             meas_timeout,
    output logic             meas_overrun,
    output logic             meas_valid,
    input  logic             meas_ready
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    // Idle timeout fires on the cycle whose increment would reach CNT_MAX,
    // so a stuck input repeats a publish every CNT_MAX cycles.
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_MAX - CNT_ONE;

    logic w_s;
    logic w_rise;
    logic w_fall;

    pwm_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock  (clock),
        .reset_n(reset_n),
        .i_async(pwm_in),
        .o_lvl  (w_s),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    state_t           r_state;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_idle_cnt;

    // Registered publish request, consumed by the handshake stage next cycle.
    logic             r_pub;
    logic [CNT_W-1:0] r_pub_high;
    logic [CNT_W-1:0] r_pub_period;
    logic             r_pub_to;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_hi_cnt     <= '0;
            r_per_cnt    <= '0;
            r_idle_cnt   <= '0;
            r_pub        <= 1'b0;
            r_pub_high   <= '0;
            r_pub_period <= '0;
            r_pub_to     <= 1'b0;
        end else begin
            r_pub <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state    <= HIGH;
                        r_hi_cnt   <= CNT_ONE;
                        r_per_cnt  <= CNT_ONE;
                        r_idle_cnt <= '0;
                    end else if (r_idle_cnt == IDLE_LAST) begin
                        r_pub        <= 1'b1;
                        r_pub_high   <= w_s ? CNT_MAX : '0;
                        r_pub_period <= CNT_MAX;
                        r_pub_to     <= 1'b1;
                        r_idle_cnt   <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + CNT_ONE;
                    end
                end
                HIGH: begin
                    // Every HIGH cycle advances the period, so saturation is checked first.
                    // hi_cnt never exceeds per_cnt, so it cannot pass CNT_MAX either.
                    if (r_per_cnt == CNT_MAX) begin
                        r_pub        <= 1'b1;
                        r_pub_high   <= r_hi_cnt;
                        r_pub_period <= CNT_MAX;
                        r_pub_to     <= 1'b1;
                        r_idle_cnt   <= '0;
                        r_state      <= IDLE;
                    end else if (w_fall) begin
                        r_per_cnt <= r_per_cnt + CNT_ONE;
                        r_state   <= LOW;
                    end else begin
                        r_hi_cnt  <= r_hi_cnt + CNT_ONE;
                        r_per_cnt <= r_per_cnt + CNT_ONE;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        r_pub        <= 1'b1;
                        r_pub_high   <= r_hi_cnt;
                        r_pub_period <= r_per_cnt;
                        r_pub_to     <= 1'b0;
                        r_hi_cnt     <= CNT_ONE;
                        r_per_cnt    <= CNT_ONE;
                        r_state      <= HIGH;
                    end else if (r_per_cnt == CNT_MAX) begin
                        r_pub        <= 1'b1;
                        r_pub_high   <= r_hi_cnt;
                        r_pub_period <= CNT_MAX;
                        r_pub_to     <= 1'b1;
                        r_idle_cnt   <= '0;
                        r_state      <= IDLE;
                    end else begin
                        r_per_cnt <= r_per_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Output handshake: a publish always wins; overrun only when the old
    // value is being dropped without having been accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meas_high    <= '0;
            meas_period  <= '0;
            meas_timeout <= 1'b0;
            meas_overrun <= 1'b0;
            meas_valid   <= 1'b0;
        end else if (r_pub) begin
            meas_high    <= r_pub_high;
            meas_period  <= r_pub_period;
            meas_timeout <= r_pub_to;
            meas_valid   <= 1'b1;
            meas_overrun <= meas_valid & ~meas_ready;
        end else if (meas_valid && meas_ready) begin
            meas_valid   <= 1'b0;
            meas_overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Purpose : directed self-checking bench for pwm_duty_meter driven by a 50-cycle PWM model.
// Latency : expects SYNC_STAGES+2 clocks from pin rise to meas_valid.
// Backpressure : exercises held valid, overrun on overwrite and accept clearing.
module tb_pwm_duty_meter;

    localparam int CNT_W   = 8;
    localparam int SYNC    = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int PER     = pwm_pkg::PWM_PERIOD;

    logic             clock;
    logic             reset_n;
    logic             pwm_in;
    logic [CNT_W-1:0] meas_high;
    logic [CNT_W-1:0] meas_period;
    logic             meas_timeout;
    logic             meas_overrun;
    logic             meas_valid;
    logic             meas_ready;

    pwm_duty_meter #(
        .CNT_W      (CNT_W),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pwm_in      (pwm_in),
        .meas_high   (meas_high),
        .meas_period (meas_period),
        .meas_timeout(meas_timeout),
        .meas_overrun(meas_overrun),
        .meas_valid  (meas_valid),
        .meas_ready  (meas_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int high;
        int period;
        int to;
        int cyc;
        int lat;
    } samp_t;

    samp_t q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    gen_cnt = 0;
    int    duty = 0;
    int    rises = 0;
    int    last_rise = 0;
    bit    gen_en = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive the PWM model just after the edge, sample at the falling edge.
    task automatic step();
        logic  pwm_new;
        samp_t s;
        @(posedge clock);
        cyc++;
        #1;
        pwm_new = 1'b0;
        if (gen_en) begin
            pwm_new = (gen_cnt < duty);
            gen_cnt = (gen_cnt == PER - 1) ? 0 : gen_cnt + 1;
        end
        if (pwm_new && !pwm_in) begin
            rises++;
            last_rise = cyc;
        end
        pwm_in = pwm_new;
        @(negedge clock);
        if (meas_valid && meas_ready) begin
            s.high   = int'(meas_high);
            s.period = int'(meas_period);
            s.to     = int'(meas_timeout);
            s.cyc    = cyc;
            s.lat    = cyc - last_rise;
            q.push_back(s);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        gen_en  = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
    endtask

    // Check entries first..last of the captured queue against one expected sample and spacing.
    task automatic check_run(input string tag, input int first, input int last,
                             input int eh, input int ep, input int eto, input int egap);
        check_val({tag, "_cnt"}, 32'(q.size() > last), 1);
        for (int i = first; i <= last && i < q.size(); i++) begin
            check_val({tag, "_high"}, q[i].high, eh);
            check_val({tag, "_period"}, q[i].period, ep);
            check_val({tag, "_timeout"}, q[i].to, eto);
            if (i > first) check_val({tag, "_gap"}, q[i].cyc - q[i-1].cyc, egap);
        end
    endtask

    initial begin
        int rise_base;
        bit found;
        reset_n    = 1'b0;
        pwm_in     = 1'b0;
        meas_ready = 1'b1;

        // Reset state
        repeat (3) step();
        check_val("rst_valid",   32'(meas_valid),   0);
        check_val("rst_overrun", 32'(meas_overrun), 0);
        check_val("rst_high",    32'(meas_high),    0);
        check_val("rst_period",  32'(meas_period),  0);
        check_val("rst_timeout", 32'(meas_timeout), 0);
        reset_n = 1'b1;

        // Input held low: idle timeouts 0/255 every 255 cycles
        q.delete();
        repeat (600) step();
        check_run("low", 0, 1, 0, CNT_MAX, 1, CNT_MAX);

        // Duty 25: first partial discarded, then 25/50 once per period
        do_reset();
        duty = 25; gen_cnt = 0; gen_en = 1'b1;
        q.delete();
        repeat (300) step();
        check_val("d25_n", q.size(), 5);
        check_run("d25", 0, 4, 25, PER, 0, PER);
        if (q.size() > 0) check_val("d25_lat", q[0].lat, SYNC + 2);

        // Duty 10, switched at a period boundary; entry 0 is the old period
        duty = 10;
        q.delete();
        repeat (200) step();
        check_run("d10", 1, 3, 10, PER, 0, PER);

        duty = 40;
        q.delete();
        repeat (250) step();
        check_run("d40", 1, 4, 40, PER, 0, PER);

        // Clamped duty 60 holds the input high: HIGH timeout then idle timeouts
        duty = 60;
        q.delete();
        repeat (900) step();
        if (q.size() > 0) check_val("hi_pre_timeout", q[0].to, 0);
        check_run("hi", 1, 3, CNT_MAX, CNT_MAX, 1, CNT_MAX);

        // Backpressure: 120 cycles not ready spans two publishes
        do_reset();
        duty = 25; gen_cnt = 0; gen_en = 1'b1; meas_ready = 1'b1;
        repeat (110) step();
        meas_ready = 1'b0;
        repeat (60) step();
        check_val("ov_pend_valid",   32'(meas_valid),   1);
        check_val("ov_pend_overrun", 32'(meas_overrun), 0);
        repeat (60) step();
        check_val("ov_valid",   32'(meas_valid),   1);
        check_val("ov_overrun", 32'(meas_overrun), 1);
        check_val("ov_high",    32'(meas_high),    25);
        check_val("ov_period",  32'(meas_period),  PER);
        check_val("ov_timeout", 32'(meas_timeout), 0);
        meas_ready = 1'b1;
        step();
        check_val("acc_valid",   32'(meas_valid),   0);
        check_val("acc_overrun", 32'(meas_overrun), 0);
        check_val("acc_high",    32'(meas_high),    25);
        check_val("acc_period",  32'(meas_period),  PER);

        // Asynchronous reset mid-HIGH with a measurement pending
        meas_ready = 1'b0;
        repeat (35) step();
        check_val("mid_pre_valid", 32'(meas_valid), 1);
        check_val("mid_pre_pwm",   32'(pwm_in),     1);
        #1 reset_n = 1'b0;
        #1;
        check_val("mid_valid",   32'(meas_valid),   0);
        check_val("mid_overrun", 32'(meas_overrun), 0);
        check_val("mid_high",    32'(meas_high),    0);
        check_val("mid_period",  32'(meas_period),  0);
        check_val("mid_timeout", 32'(meas_timeout), 0);
        repeat (17) step();
        reset_n    = 1'b1;
        meas_ready = 1'b1;
        q.delete();
        rise_base = rises;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (q.size() > 0) found = 1'b1;
        end
        check_val("post_rst_found", 32'(found), 1);
        if (found) begin
            check_val("post_rst_high",    q[0].high,   25);
            check_val("post_rst_period",  q[0].period, PER);
            check_val("post_rst_timeout", q[0].to,     0);
            check_val("post_rst_rises",   rises - rise_base, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwm_duty_meter.md
Name: pwm_duty_meter

Overview:
Downstream consumer of the 50-cycle PWM generator output. Samples a 1-bit PWM waveform and measures high time and period in clock cycles, rising edge to rising edge. Publishes each completed measurement through a valid/ready interface toward the display/readback logic. Detects a stuck input (0% or 100% duty) with a saturating timeout.

Parameters:
CNT_W, 8, width of the high-time and period counters; saturation value CNT_MAX = 2^CNT_W-1 (255).
SYNC_STAGES, 2, number of input synchronizer flops (minimum 2).

Ports:
clock  input  1  sole clock, rising-edge.
reset_n  input  1  asynchronous, active-low reset; clears all state.
pwm_in  input  1  PWM waveform, asynchronous to clock.
meas_high  output  CNT_W  high-time of last published measurement, in cycles.
meas_period  output  CNT_W  period of last published measurement, in cycles.
meas_timeout  output  1  published measurement came from a timeout (stuck input).
meas_overrun  output  1  an unconsumed measurement was overwritten.
meas_valid  output  1  measurement available; held until accepted.
meas_ready  input  1  consumer accepts when meas_valid && meas_ready at a rising edge.

Behaviour:
- Reset values: all outputs 0; synchronizer flops 0; state IDLE; counters 0.
- Sync: pwm_in passes through SYNC_STAGES flops giving s. Registered copy s_d gives rise = s & ~s_d and fall = ~s & s_d.
- IDLE: waits for rise. idle_cnt increments every cycle.
  - On rise: go to HIGH, hi_cnt = 1, per_cnt = 1, idle_cnt = 0.
  - If idle_cnt reaches CNT_MAX: publish high = (s ? CNT_MAX : 0), period = CNT_MAX, timeout = 1. Then idle_cnt = 0 and stay in IDLE.
- HIGH: each cycle with s=1, hi_cnt++ and per_cnt++.
  - On fall: per_cnt++ and go to LOW.
- LOW: each cycle with s=0, per_cnt++.
  - On rise: publish high = hi_cnt, period = per_cnt, timeout = 0. Restart with hi_cnt = 1, per_cnt = 1 and stay in HIGH.
- Timeout in HIGH/LOW: if per_cnt would exceed CNT_MAX, publish high = min(hi_cnt, CNT_MAX), period = CNT_MAX, timeout = 1. Go to IDLE with idle_cnt = 0.
- Counters saturate at CNT_MAX and never wrap.
- First partial period after reset or after a timeout is never published.
- Publish: loads meas_high, meas_period and meas_timeout, and sets meas_valid = 1 on the next edge.
  - Publish while meas_valid=1 and meas_ready=0: data overwritten, meas_overrun = 1.
  - Publish in the same cycle as an accept: new data loads, meas_valid stays 1, meas_overrun = 0.
- Accept with no publish: meas_valid = 0 and meas_overrun = 0 next cycle. Data registers hold.
- Latency: pwm_in rising edge at the pin to meas_valid high is SYNC_STAGES+2 clocks.
- reset_n low at any time, including mid-period or with meas_valid pending: immediate clear to reset values; pending measurement lost.

Decomposition:
- Shared package pwm_pkg:
  - state enum {IDLE, HIGH, LOW}.
  - PWM_PERIOD = 50, shared with the generator.
  - Default CNT_W.
- One sub-module, pwm_sync_edge: SYNC_STAGES synchronizer plus rise/fall detect, with reset_n. Reusable for other async inputs.
- FSM, counters and output handshake stay in pwm_duty_meter.

Test Plan:
- Generator at duty 25 (25 high / 25 low), meas_ready=1 → after the first discarded partial, each period yields high=25, period=50, timeout=0, one valid per 50 cycles.
- Duty 10 → high=10, period=50. Switch to duty 40 mid-run → one transitional sample, then high=40, period=50.
- Input held high, i.e. duty 50 or a clamped duty 60 → first timeout publish has timeout=1, period=255; subsequent publishes every 255 cycles show high=255, period=255.
- Input held low (duty 0) → high=0, period=255, timeout=1, repeating every 255 cycles in IDLE.
- Duty 25, meas_ready=0 for 120 cycles, then 1 → meas_valid stays high, meas_overrun=1, data shows the most recent 25/50. Accept clears both flags.
- reset_n pulsed low mid-HIGH with meas_valid=1 → all outputs 0 immediately. First post-reset publish occurs only after two rising edges and reads 25/50.
